sw_debounce_pio: RTL and testbench

Avalon-MM slave peripheral on the Nios II system bus that presents the board slide switches to the processor. It is the responder side of the processor's PIO accesses: it synchronizes and debounces `sw_in`, exposes debounced and raw values, captures edges per bit and raises a maskable interrupt. It replaces the bare switch PIO inside the Platform Designer system and sits between the `SW` pins and the Nios data master.

---
 rtl/sw_debounce_pio.sv | 118 +++++++++++
 tb/tb_sw_debounce_pio.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce_pio.sv
// Slide-switch PIO: 2-flop sync, per-bit debounce, edge capture with maskable level irq.
// Latency: sw_in to DATA/EDGE in DEBOUNCE_CYCLES+2 edges; registered readdata 1 cycle after avs_read.
// Backpressure: none; zero-wait-state slave, every read/write strobe is accepted on the edge it is sampled.
module sw_debounce_pio #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  sw_in,
    input  logic [1:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_RAW  = 2'd3;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_nxt;
    logic [WIDTH-1:0] mask_reg;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] wr_dat;
    logic [CW-1:0]    cnt     [WIDTH];
    logic [CW-1:0]    cnt_nxt [WIDTH];
    logic [31:0]      rd_word;

    assign wr_dat   = avs_writedata[WIDTH-1:0];
    assign edge_clr = (avs_write && avs_address == ADDR_EDGE) ? wr_dat : '0;

    generate
        if (WIDTH < 32) begin : g_unused
            logic unused_wd;
            assign unused_wd = &{1'b0, avs_writedata[31:WIDTH]};
        end
    endgenerate

    // A mismatch must persist for DEBOUNCE_CYCLES consecutive cycles; any return to
    // the stable level restarts the count, so short glitches never commit.
    always_comb begin
        stable_nxt = stable;
        edge_set   = '0;
        cnt_nxt    = cnt;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2[i] == stable[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_MAX) begin
                stable_nxt[i] = sync2[i];
                cnt_nxt[i]    = '0;
                edge_set[i]   = 1'b1;
            end else begin
                cnt_nxt[i] = cnt[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1  <= sw_in;
            sync2  <= sync1;
            stable <= stable_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        case (avs_address)
            ADDR_DATA: rd_word[WIDTH-1:0] = stable;
            ADDR_MASK: rd_word[WIDTH-1:0] = mask_reg;
            ADDR_EDGE: rd_word[WIDTH-1:0] = edge_cap;
            ADDR_RAW:  rd_word[WIDTH-1:0] = sync2;
            default:   rd_word = '0;
        endcase
    end

    // Read mux samples pre-write state, so a simultaneous read+write returns the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_reg     <= '0;
            edge_cap     <= '0;
            avs_readdata <= '0;
        end else begin
            if (avs_write && avs_address == ADDR_MASK) begin
                mask_reg <= wr_dat;
            end
            // Set has priority over a same-cycle write-1-clear so no edge is lost.
            edge_cap <= (edge_cap & ~edge_clr) | edge_set;
            if (avs_read) begin
                avs_readdata <= rd_word;
            end
        end
    end

    assign irq = |(edge_cap & mask_reg);

endmodule

// File: tb/tb_sw_debounce_pio.sv
// Directed bench for sw_debounce_pio at WIDTH=4, DEBOUNCE_CYCLES=4.
// Each task drives one scenario and compares against hand-computed values.
module tb_sw_debounce_pio;

    logic        clk;
    logic        reset;
    logic [3:0]  sw_in;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        irq;

    int pass_cnt;
    int total_cnt;

    sw_debounce_pio #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sw_in         (sw_in),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_address = a;
        avs_read    = 1'b1;
        @(posedge clk);
        #1;
        d        = avs_readdata;
        avs_read = 1'b0;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] v);
        @(negedge clk);
        avs_address   = a;
        avs_writedata = v;
        avs_write     = 1'b1;
        @(posedge clk);
        #1;
        avs_write = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        sw_in = 4'h0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        #1;
        total_cnt++;
        if (avs_readdata !== 32'h0) $display("FAIL reset_init_readdata got=%h exp=%h", avs_readdata, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL reset_init_irq got=%b exp=0", irq);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        sw_in = 4'hF;
        repeat (8) @(posedge clk);
        bus_wr(2'd1, 32'hF);
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL reset_pre_irq got=%b exp=1", irq);
        else pass_cnt++;
        bus_rd(2'd0, d);
        total_cnt++;
        if (d !== 32'hF) $display("FAIL reset_pre_data got=%h exp=%h", d, 32'hF);
        else pass_cnt++;
        // Assert reset between edges: outputs must clear without a clock.
        @(posedge clk);
        #3;
        sw_in = 4'hA;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (avs_readdata !== 32'h0) $display("FAIL reset_async_readdata got=%h exp=%h", avs_readdata, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL reset_async_irq got=%b exp=0", irq);
        else pass_cnt++;
        repeat (3) begin
            @(negedge clk);
            sw_in = ~sw_in;
        end
        sw_in = 4'h0;
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            bus_rd(a[1:0], d);
            total_cnt++;
            if (d !== 32'h0) $display("FAIL reset_read_addr%0d got=%h exp=%h", a, d, 32'h0);
            else pass_cnt++;
        end
    endtask

    task automatic test_debounce_latency();
        logic [31:0] d;
        logic [31:0] exp;
        do_reset();
        @(negedge clk);
        sw_in       = 4'h5;
        avs_address = 2'd0;
        avs_read    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            exp = (k >= 6) ? 32'h5 : 32'h0;
            total_cnt++;
            if (avs_readdata !== exp) $display("FAIL latency_data_E%0d got=%h exp=%h", k, avs_readdata, exp);
            else pass_cnt++;
        end
        avs_read = 1'b0;
        bus_rd(2'd2, d);
        total_cnt++;
        if (d !== 32'h5) $display("FAIL latency_edge got=%h exp=%h", d, 32'h5);
        else pass_cnt++;
        do_reset();
        @(negedge clk);
        sw_in       = 4'h5;
        avs_address = 2'd3;
        avs_read    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            exp = (k >= 2) ? 32'h5 : 32'h0;
            total_cnt++;
            if (avs_readdata !== exp) $display("FAIL latency_raw_E%0d got=%h exp=%h", k, avs_readdata, exp);
            else pass_cnt++;
        end
        avs_read = 1'b0;
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        int hi_cnt;
        hi_cnt = 0;
        do_reset();
        @(negedge clk);
        sw_in       = 4'h1;
        avs_address = 2'd3;
        avs_read    = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
            if (avs_readdata[0]) hi_cnt++;
            if (k == 2) sw_in = 4'h0;
        end
        avs_read = 1'b0;
        total_cnt++;
        if (hi_cnt != 3) $display("FAIL glitch_raw_pulse_len got=%0d exp=3", hi_cnt);
        else pass_cnt++;
        repeat (6) @(posedge clk);
        bus_rd(2'd0, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL glitch_data got=%h exp=%h", d, 32'h0);
        else pass_cnt++;
        bus_rd(2'd2, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL glitch_edge got=%h exp=%h", d, 32'h0);
        else pass_cnt++;
    endtask

    task automatic test_irq_clear();
        logic [31:0] d;
        do_reset();
        bus_wr(2'd1, 32'h1);
        @(negedge clk);
        sw_in = 4'h5;
        repeat (8) @(posedge clk);
        #1;
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL irq_after_debounce got=%b exp=1", irq);
        else pass_cnt++;
        bus_rd(2'd2, d);
        total_cnt++;
        if (d !== 32'h5) $display("FAIL irq_edge_before_clear got=%h exp=%h", d, 32'h5);
        else pass_cnt++;
        bus_wr(2'd2, 32'h1);
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL irq_after_clear got=%b exp=0", irq);
        else pass_cnt++;
        bus_rd(2'd2, d);
        total_cnt++;
        if (d !== 32'h4) $display("FAIL irq_edge_after_clear got=%h exp=%h", d, 32'h4);
        else pass_cnt++;
        bus_wr(2'd1, 32'h4);
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL irq_mask4 got=%b exp=1", irq);
        else pass_cnt++;
    endtask

    // Continues from test_irq_clear: stable=0x5, EDGE=0x4.
    task automatic test_clear_set_collision();
        logic [31:0] d;
        bus_wr(2'd1, 32'h2);
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL coll_irq_pre got=%b exp=0", irq);
        else pass_cnt++;
        @(negedge clk);
        sw_in = 4'h7;
        repeat (5) @(posedge clk);
        @(negedge clk);
        avs_address   = 2'd2;
        avs_writedata = 32'h2;
        avs_write     = 1'b1;
        @(posedge clk);
        #1;
        avs_write = 1'b0;
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL coll_irq got=%b exp=1", irq);
        else pass_cnt++;
        bus_rd(2'd2, d);
        total_cnt++;
        if (d !== 32'h6) $display("FAIL coll_edge got=%h exp=%h", d, 32'h6);
        else pass_cnt++;
    endtask

    task automatic test_falling_and_reset();
        logic [31:0] d;
        do_reset();
        @(negedge clk);
        sw_in = 4'hF;
        repeat (8) @(posedge clk);
        bus_wr(2'd2, 32'hF);
        bus_wr(2'd1, 32'hF);
        @(negedge clk);
        sw_in = 4'h0;
        repeat (6) @(posedge clk);
        #1;
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL fall_irq got=%b exp=1", irq);
        else pass_cnt++;
        bus_rd(2'd0, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL fall_data got=%h exp=%h", d, 32'h0);
        else pass_cnt++;
        bus_rd(2'd2, d);
        total_cnt++;
        if (d !== 32'hF) $display("FAIL fall_edge got=%h exp=%h", d, 32'hF);
        else pass_cnt++;
        @(negedge clk);
        sw_in = 4'hF;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL midreset_irq got=%b exp=0", irq);
        else pass_cnt++;
        sw_in = 4'h0;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        bus_rd(2'd0, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL midreset_data got=%h exp=%h", d, 32'h0);
        else pass_cnt++;
        bus_rd(2'd2, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL midreset_edge got=%h exp=%h", d, 32'h0);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        reset         = 1'b1;
        sw_in         = 4'h0;
        avs_address   = 2'd0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = 32'h0;
        test_reset();
        test_debounce_latency();
        test_glitch();
        test_irq_clear();
        test_clear_set_collision();
        test_falling_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
